// File: rtl/mem_stage_mc.sv
// mem_stage_mc
// MEM pipeline stage of the MIPS core, fed by the EX/MEM register and
// feeding WB. Load data comes back from the data SRAM with a variable
// latency, one dmem_rvalid_i pulse per issued load and in order. While a
// load is waiting for its data, the stage stalls the pipeline itself through
// mem_stall_o. A response that belongs to a flushed or timed-out load is
// swallowed in DRAIN, so it can never be paired with a later load.
// memop bit order, starting at bit 0: lb, lbu, lh, lhu, lw, lwl, lwr.
module mem_stage_mc #(
  parameter int PC_W    = 32,
  parameter int RADDR_W = 5,
  parameter int MOP_W   = 7,
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    mem_inst_i,
  input  logic [PC_W-1:0]    mem_pc_i,
  input  logic               mem_inslot_i,
  input  logic [MOP_W-1:0]   mem_memop_i,
  input  logic [1:0]         mem_memaddr_low_i,
  input  logic [31:0]        mem_rt_i,
  input  logic [RADDR_W-1:0] mem_waddr_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic               mem_wren_i,
  input  logic               mem_nofwd_i,
  input  logic               mem_inst_load_i,
  input  logic [31:0]        dmem_rdata_i,
  input  logic               dmem_rvalid_i,
  input  logic               mem_stall_i,
  input  logic               mem_flush_i,
  output logic [PC_W-1:0]    mem_inst_o,
  output logic [PC_W-1:0]    mem_pc_o,
  output logic               mem_inslot_o,
  output logic               mem_wren_o,
  output logic [RADDR_W-1:0] mem_waddr_o,
  output logic [31:0]        mem_wdata_o,
  output logic [31:0]        mem_wdata_bp,
  output logic               mem_nofwd_bp,
  output logic               mem_stall_o,
  output logic               mem_buserr_o
);

  // Load-response tracking states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // A TIMEOUT of zero turns the response timer off entirely
  localparam logic             TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic [31:0]      buf_q;
  logic [31:0]      buf_d;
  logic             buserr_q;

  logic             in_hold;
  logic             data_avail;
  logic             timeout_hit;
  logic [31:0]      load_data;
  logic [31:0]      load_result;
  logic [31:0]      stage_result;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      lwl_val;
  logic [31:0]      lwr_val;

  // HOLD replays the captured word; otherwise data comes straight from the SRAM
  assign in_hold    = (state_q == ST_HOLD);
  assign data_avail = dmem_rvalid_i | in_hold;
  assign load_data  = in_hold ? buf_q : dmem_rdata_i;

  // The timer only counts while a response is missing; a response that
  // arrives on the last allowed cycle still completes the load, and a flush
  // on that cycle takes over instead of raising a bus error.
  assign timeout_hit = TMO_EN && (state_q == ST_WAIT) && !dmem_rvalid_i &&
                       (tmr_q == TMR_LAST) && !mem_flush_i;

  assign mem_stall_o  = (mem_inst_load_i & ~data_avail) | (state_q == ST_DRAIN);
  assign mem_nofwd_bp = mem_nofwd_i | mem_stall_o;

  assign stage_result = mem_inst_load_i ? load_result : mem_wdata_i;
  assign mem_wdata_bp = stage_result;
  assign mem_buserr_o = buserr_q;

  // Extract and merge the load result for the selected op and byte offset
  always_comb begin
    case (mem_memaddr_low_i)
      2'd0:    sel_byte = load_data[7:0];
      2'd1:    sel_byte = load_data[15:8];
      2'd2:    sel_byte = load_data[23:16];
      default: sel_byte = load_data[31:24];
    endcase

    sel_half = mem_memaddr_low_i[1] ? load_data[31:16] : load_data[15:0];

    case (mem_memaddr_low_i)
      2'd0:    lwl_val = {load_data[7:0],  mem_rt_i[23:0]};
      2'd1:    lwl_val = {load_data[15:0], mem_rt_i[15:0]};
      2'd2:    lwl_val = {load_data[23:0], mem_rt_i[7:0]};
      default: lwl_val = load_data;
    endcase

    case (mem_memaddr_low_i)
      2'd0:    lwr_val = load_data;
      2'd1:    lwr_val = {mem_rt_i[31:24], load_data[31:8]};
      2'd2:    lwr_val = {mem_rt_i[31:16], load_data[31:16]};
      default: lwr_val = {mem_rt_i[31:8],  load_data[31:24]};
    endcase

    load_result = 32'h0;
    if (mem_memop_i[0])      load_result = {{24{sel_byte[7]}}, sel_byte};
    else if (mem_memop_i[1]) load_result = {24'h0, sel_byte};
    else if (mem_memop_i[2]) load_result = {{16{sel_half[15]}}, sel_half};
    else if (mem_memop_i[3]) load_result = {16'h0, sel_half};
    else if (mem_memop_i[4]) load_result = load_data;
    else if (mem_memop_i[5]) load_result = lwl_val;
    else if (mem_memop_i[6]) load_result = lwr_val;
  end

  // Next state, wait timer and capture buffer
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    buf_d   = buf_q;

    if (mem_flush_i) begin
      // A flushed load whose response is still in flight must be drained;
      // if the response shows up on the flush cycle itself it is simply
      // dropped here, as nothing is left outstanding.
      if (((state_q == ST_IDLE) && mem_inst_load_i && !dmem_rvalid_i) ||
          ((state_q == ST_WAIT)  && !dmem_rvalid_i) ||
          ((state_q == ST_DRAIN) && !dmem_rvalid_i)) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_inst_load_i) begin
            if (dmem_rvalid_i) begin
              if (mem_stall_i) begin
                buf_d   = dmem_rdata_i;
                state_d = ST_HOLD;
              end
            end else begin
              tmr_d   = '0;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid_i) begin
            buf_d   = dmem_rdata_i;
            state_d = mem_stall_i ? ST_HOLD : ST_IDLE;
          end else if (timeout_hit) begin
            state_d = ST_DRAIN;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_HOLD: begin
          if (!mem_stall_i) state_d = ST_IDLE;
        end
        default: begin
          if (dmem_rvalid_i) state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state, timer, buffer and bus-error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      buf_q    <= 32'h0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      buf_q    <= buf_d;
      buserr_q <= timeout_hit;
    end
  end

  // MEM/WB output register: flush clears, stall holds, self-stall bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_inst_o   <= '0;
      mem_pc_o     <= '0;
      mem_inslot_o <= 1'b0;
      mem_waddr_o  <= '0;
      mem_wren_o   <= 1'b0;
      mem_wdata_o  <= 32'h0;
    end else if (mem_flush_i) begin
      mem_inst_o   <= '0;
      mem_pc_o     <= '0;
      mem_inslot_o <= 1'b0;
      mem_waddr_o  <= '0;
      mem_wren_o   <= 1'b0;
      mem_wdata_o  <= 32'h0;
    end else if (mem_stall_i) begin
      mem_inst_o   <= mem_inst_o;
      mem_pc_o     <= mem_pc_o;
      mem_inslot_o <= mem_inslot_o;
      mem_waddr_o  <= mem_waddr_o;
      mem_wren_o   <= mem_wren_o;
      mem_wdata_o  <= mem_wdata_o;
    end else if (mem_stall_o) begin
      mem_inst_o   <= '0;
      mem_pc_o     <= '0;
      mem_inslot_o <= 1'b0;
      mem_waddr_o  <= '0;
      mem_wren_o   <= 1'b0;
      mem_wdata_o  <= 32'h0;
    end else begin
      mem_inst_o   <= mem_inst_i;
      mem_pc_o     <= mem_pc_i;
      mem_inslot_o <= mem_inslot_i;
      mem_waddr_o  <= mem_waddr_i;
      mem_wren_o   <= mem_wren_i;
      mem_wdata_o  <= stage_result;
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc
// Drives instructions through mem_stage_mc with random and directed SRAM
// response timing. Every instruction that should write back is queued with
// its expected values when issued; a monitor pops one entry for each new
// write-back the stage presents.
module tb_mem_stage_mc;

  localparam int PC_W    = 32;
  localparam int RADDR_W = 5;
  localparam int MOP_W   = 7;
  localparam int TIMEOUT = 4;
  localparam int TMR_W   = 8;

  localparam logic [6:0] OP_LB  = 7'b0000001;
  localparam logic [6:0] OP_LBU = 7'b0000010;
  localparam logic [6:0] OP_LH  = 7'b0000100;
  localparam logic [6:0] OP_LHU = 7'b0001000;
  localparam logic [6:0] OP_LW  = 7'b0010000;
  localparam logic [6:0] OP_LWL = 7'b0100000;
  localparam logic [6:0] OP_LWR = 7'b1000000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [PC_W-1:0]    mem_inst_i;
  logic [PC_W-1:0]    mem_pc_i;
  logic               mem_inslot_i;
  logic [MOP_W-1:0]   mem_memop_i;
  logic [1:0]         mem_memaddr_low_i;
  logic [31:0]        mem_rt_i;
  logic [RADDR_W-1:0] mem_waddr_i;
  logic [31:0]        mem_wdata_i;
  logic               mem_wren_i;
  logic               mem_nofwd_i;
  logic               mem_inst_load_i;
  logic [31:0]        dmem_rdata_i;
  logic               dmem_rvalid_i;
  logic               mem_stall_i;
  logic               mem_flush_i;
  logic [PC_W-1:0]    mem_inst_o;
  logic [PC_W-1:0]    mem_pc_o;
  logic               mem_inslot_o;
  logic               mem_wren_o;
  logic [RADDR_W-1:0] mem_waddr_o;
  logic [31:0]        mem_wdata_o;
  logic [31:0]        mem_wdata_bp;
  logic               mem_nofwd_bp;
  logic               mem_stall_o;
  logic               mem_buserr_o;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inslot;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          buserr_seen = 0;
  int          buserr_exp = 0;
  logic        armed = 1'b0;
  logic [31:0] pc_cnt = 32'h0000_1000;
  logic [31:0] prev_wdata = 32'h0;
  logic        prev_wren = 1'b0;

  mem_stage_mc #(
    .PC_W(PC_W), .RADDR_W(RADDR_W), .MOP_W(MOP_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_inst_i(mem_inst_i), .mem_pc_i(mem_pc_i), .mem_inslot_i(mem_inslot_i),
    .mem_memop_i(mem_memop_i), .mem_memaddr_low_i(mem_memaddr_low_i), .mem_rt_i(mem_rt_i),
    .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i), .mem_wren_i(mem_wren_i),
    .mem_nofwd_i(mem_nofwd_i), .mem_inst_load_i(mem_inst_load_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
    .mem_stall_i(mem_stall_i), .mem_flush_i(mem_flush_i),
    .mem_inst_o(mem_inst_o), .mem_pc_o(mem_pc_o), .mem_inslot_o(mem_inslot_o),
    .mem_wren_o(mem_wren_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wdata_bp(mem_wdata_bp), .mem_nofwd_bp(mem_nofwd_bp),
    .mem_stall_o(mem_stall_o), .mem_buserr_o(mem_buserr_o)
  );

  always #5 clk = ~clk;

  // Reference load semantics in terms of byte shifts and masks
  function automatic logic [31:0] refLoad(input logic [6:0] op, input logic [1:0] a,
                                          input logic [31:0] rt, input logic [31:0] d);
    int          ai;
    int          keep;
    logic [31:0] byte_v;
    logic [31:0] half_v;
    ai     = int'(a);
    byte_v = (d >> (8 * ai)) & 32'h0000_00FF;
    half_v = (d >> (16 * (ai / 2))) & 32'h0000_FFFF;
    case (op)
      OP_LB:   return byte_v[7]  ? (byte_v | 32'hFFFF_FF00) : byte_v;
      OP_LBU:  return byte_v;
      OP_LH:   return half_v[15] ? (half_v | 32'hFFFF_0000) : half_v;
      OP_LHU:  return half_v;
      OP_LW:   return d;
      OP_LWL: begin
        keep = 3 - ai;
        return (d << (8 * keep)) | (rt & ((32'h1 << (8 * keep)) - 32'h1));
      end
      OP_LWR:  return (d >> (8 * ai)) | (rt & ~(32'hFFFF_FFFF >> (8 * ai)));
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setNop();
    mem_inst_i = '0; mem_pc_i = '0; mem_inslot_i = 1'b0; mem_memop_i = '0;
    mem_memaddr_low_i = 2'd0; mem_rt_i = 32'h0; mem_waddr_i = '0; mem_wdata_i = 32'h0;
    mem_wren_i = 1'b0; mem_nofwd_i = 1'b0; mem_inst_load_i = 1'b0;
    dmem_rdata_i = 32'h0; dmem_rvalid_i = 1'b0; mem_stall_i = 1'b0; mem_flush_i = 1'b0;
  endtask

  task automatic presentInst(input logic is_load, input logic [6:0] op, input logic [1:0] a,
                             input logic [31:0] rt, input logic [31:0] alu);
    pc_cnt            = pc_cnt + 32'd4;
    mem_pc_i          = pc_cnt;
    mem_inst_i        = $urandom;
    mem_inslot_i      = 1'($urandom_range(0, 1));
    mem_waddr_i       = 5'($urandom_range(1, 31));
    mem_nofwd_i       = 1'($urandom_range(0, 1));
    mem_wren_i        = 1'b1;
    mem_wdata_i       = alu;
    mem_inst_load_i   = is_load;
    mem_memop_i       = is_load ? op : 7'b0;
    mem_memaddr_low_i = a;
    mem_rt_i          = rt;
    dmem_rvalid_i     = 1'b0;
    dmem_rdata_i      = $urandom;
    mem_stall_i       = 1'b0;
    mem_flush_i       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction: lat cycles without data, then the response,
  // then hold_cyc cycles of external stall starting on the response cycle
  task automatic applyStimulus(input logic is_load, input logic [6:0] op, input logic [1:0] a,
                               input logic [31:0] rt, input logic [31:0] rdata,
                               input logic [31:0] alu, input int lat, input int hold_cyc);
    logic [31:0] res;
    logic [31:0] held_wdata;
    logic        held_wren;
    wb_t         e;
    presentInst(is_load, op, a, rt, alu);
    res     = is_load ? refLoad(op, a, rt, rdata) : alu;
    e.inst  = mem_inst_i;
    e.pc    = mem_pc_i;
    e.inslot = mem_inslot_i;
    e.waddr = mem_waddr_i;
    e.wdata = res;
    exp_q.push_back(e);
    held_wdata = prev_wdata;
    held_wren  = prev_wren;
    if (is_load) begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        checkOutput("stall_wait", 32'(mem_stall_o), 32'd1);
        checkOutput("nofwd_wait", 32'(mem_nofwd_bp), 32'd1);
        step();
      end
      if (lat > 0) begin
        held_wdata = 32'h0;
        held_wren  = 1'b0;
      end
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
    end
    mem_stall_i = (hold_cyc > 0);
    @(negedge clk);
    checkOutput("stall_data", 32'(mem_stall_o), 32'd0);
    checkOutput("wdata_bp", mem_wdata_bp, res);
    checkOutput("nofwd_data", 32'(mem_nofwd_bp), 32'(mem_nofwd_i));
    step();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = $urandom;
    if (hold_cyc > 0) begin
      for (int i = 0; i <= hold_cyc; i++) begin
        mem_stall_i = (i < hold_cyc - 1);
        @(negedge clk);
        checkOutput("hold_stall", 32'(mem_stall_o), 32'd0);
        checkOutput("hold_bp", mem_wdata_bp, res);
        checkOutput("hold_wren", 32'(mem_wren_o), 32'(held_wren));
        checkOutput("hold_wdata", mem_wdata_o, held_wdata);
        step();
        if (!mem_stall_i) break;
      end
    end
    mem_stall_i = 1'b0;
    prev_wdata  = res;
    prev_wren   = 1'b1;
  endtask

  // Monitor: one scoreboard entry per freshly registered write-back
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_buserr_o) buserr_seen++;
      if (armed && mem_wren_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wb: got pc 0x%08h wdata 0x%08h, expected no write", mem_pc_o, mem_wdata_o);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("wb_pc", mem_pc_o, mon_e.pc);
          checkOutput("wb_inst", mem_inst_o, mon_e.inst);
          checkOutput("wb_waddr", 32'(mem_waddr_o), 32'(mon_e.waddr));
          checkOutput("wb_inslot", 32'(mem_inslot_o), 32'(mon_e.inslot));
          checkOutput("wb_wdata", mem_wdata_o, mon_e.wdata);
        end
      end
      armed = !mem_stall_i && !mem_flush_i;
    end else begin
      armed = 1'b0;
    end
  end

  initial begin
    setNop();
    #1 rst_n = 1'b0;
    #11;
    checkOutput("rst_wdata", mem_wdata_o, 32'h0);
    checkOutput("rst_wren", 32'(mem_wren_o), 32'd0);
    checkOutput("rst_pc", mem_pc_o, 32'h0);
    checkOutput("rst_buserr", 32'(mem_buserr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("[TB] directed loads");
    applyStimulus(1'b1, OP_LW,  2'd0, 32'h0,        32'h8899AABB, 32'h0, 0, 0);
    applyStimulus(1'b1, OP_LB,  2'd3, 32'h0,        32'h80112233, 32'h0, 3, 0);
    applyStimulus(1'b1, OP_LWL, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h0, 1, 0);
    applyStimulus(1'b1, OP_LWR, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h0, 0, 0);
    applyStimulus(1'b0, 7'b0,   2'd0, 32'h0,        32'h0,        32'h12345678, 0, 2);
    applyStimulus(1'b1, OP_LHU, 2'd2, 32'h0,        32'hBEEF0000, 32'h0, 0, 2);
    applyStimulus(1'b1, OP_LH,  2'd3, 32'h0,        32'h80010000, 32'h0, 4, 0);
    applyStimulus(1'b1, 7'b0,   2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5555, 0, 0);

    $display("[TB] flush while waiting");
    applyStimulus(1'b0, 7'b0, 2'd0, 32'h0, 32'h0, 32'hA5A5A5A5, 0, 0);
    presentInst(1'b1, OP_LW, 2'd0, 32'h0, 32'h0);
    mem_stall_i = 1'b1;
    step();
    mem_flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_wait_stall", 32'(mem_stall_o), 32'd1);
    step();
    setNop();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEADBEEF;
      end
      @(negedge clk);
      if (i == 0) begin
        checkOutput("flush_wren", 32'(mem_wren_o), 32'd0);
        checkOutput("flush_wdata", mem_wdata_o, 32'h0);
      end
      checkOutput("drain_stall", 32'(mem_stall_o), 32'd1);
      step();
    end
    setNop();
    prev_wdata = 32'h0;
    prev_wren  = 1'b0;
    applyStimulus(1'b1, OP_LW, 2'd0, 32'h0, 32'h01020304, 32'h0, 0, 0);

    $display("[TB] flush with data present and in hold");
    presentInst(1'b1, OP_LW, 2'd0, 32'h0, 32'h0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h77777777;
    mem_flush_i   = 1'b1;
    step();
    setNop();
    @(negedge clk);
    checkOutput("flush_idle_wren", 32'(mem_wren_o), 32'd0);
    step();
    presentInst(1'b1, OP_LHU, 2'd0, 32'h0, 32'h0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h0000CAFE;
    mem_stall_i   = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    mem_flush_i   = 1'b1;
    step();
    setNop();
    prev_wdata = 32'h0;
    prev_wren  = 1'b0;
    applyStimulus(1'b1, OP_LW, 2'd0, 32'h0, 32'h13572468, 32'h0, 0, 0);

    $display("[TB] response timeout");
    presentInst(1'b1, OP_LW, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      @(negedge clk);
      checkOutput("tmo_stall", 32'(mem_stall_o), 32'd1);
      checkOutput("tmo_noerr", 32'(mem_buserr_o), 32'd0);
      step();
    end
    setNop();
    buserr_exp++;
    @(negedge clk);
    checkOutput("tmo_buserr", 32'(mem_buserr_o), 32'd1);
    checkOutput("tmo_wren", 32'(mem_wren_o), 32'd0);
    checkOutput("tmo_drain_stall", 32'(mem_stall_o), 32'd1);
    step();
    @(negedge clk);
    checkOutput("tmo_pulse_end", 32'(mem_buserr_o), 32'd0);
    checkOutput("tmo_drain_stall2", 32'(mem_stall_o), 32'd1);
    step();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hBAD0BAD0;
    step();
    setNop();
    prev_wdata = 32'h0;
    prev_wren  = 1'b0;
    applyStimulus(1'b1, OP_LBU, 2'd1, 32'h0, 32'h0000F100, 32'h0, 0, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      applyStimulus(1'($urandom_range(0, 9) < 7), 7'(1 << $urandom_range(0, 6)),
                    2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    $display("[TB] reset during wait");
    applyStimulus(1'b0, 7'b0, 2'd0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0);
    presentInst(1'b1, OP_LW, 2'd0, 32'h0, 32'h0);
    mem_stall_i = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_wdata", mem_wdata_o, 32'h0);
    checkOutput("rst_mid_wren", 32'(mem_wren_o), 32'd0);
    checkOutput("rst_mid_pc", mem_pc_o, 32'h0);
    checkOutput("rst_mid_inst", mem_inst_o, 32'h0);
    setNop();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    prev_wdata = 32'h0;
    prev_wren  = 1'b0;
    applyStimulus(1'b1, OP_LW, 2'd0, 32'h0, 32'h2468ACE0, 32'h0, 0, 0);
    setNop();
    step();
    step();

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("buserr_count", 32'(buserr_seen), 32'(buserr_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
- MEM pipeline stage for the MIPS core, successor to the single-cycle MEM stage.
- Accepts data-SRAM read responses with variable latency: a valid/handshake response replaces the fixed next-cycle data.
- Generates its own stall while a load is outstanding and drains orphaned responses after a flush.
- Adds LWL/LWR merge and a response timeout. Sits between the EX/MEM register and WB.

Parameters:
- PC_W, 32, width of PC and instruction fields.
- RADDR_W, 5, register-file write-address width.
- MOP_W, 7, one-hot load-op width; bit order: lb, lbu, lh, lhu, lw, lwl, lwr.
- TIMEOUT, 255, max cycles waiting for rvalid; 0 disables the timeout.
- TMR_W, 8, timeout counter width; must satisfy TIMEOUT < 2^TMR_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_inst_i  in  PC_W  instruction
- mem_pc_i  in  PC_W  PC
- mem_inslot_i  in  1  delay-slot flag
- mem_memop_i  in  MOP_W  one-hot load op
- mem_memaddr_low_i  in  2  byte offset
- mem_rt_i  in  32  old rt value, used by lwl/lwr
- mem_waddr_i  in  RADDR_W  dest register
- mem_wdata_i  in  32  non-load result
- mem_wren_i  in  1  write enable
- mem_nofwd_i  in  1  no-forward flag from EX
- mem_inst_load_i  in  1  current inst is a load
- dmem_rdata_i  in  32  SRAM read data
- dmem_rvalid_i  in  1  read data valid, one pulse per issued load, in order
- mem_stall_i  in  1  downstream/global stall
- mem_flush_i  in  1  flush
- mem_inst_o, mem_pc_o  out  PC_W  registered
- mem_inslot_o, mem_wren_o  out  1  registered
- mem_waddr_o  out  RADDR_W  registered
- mem_wdata_o  out  32  registered
- mem_wdata_bp  out  32  bypass data, combinational
- mem_nofwd_bp  out  1  bypass inhibit, combinational
- mem_stall_o  out  1  stage stall, combinational
- mem_buserr_o  out  1  registered 1-cycle timeout pulse

Behaviour:
- Reset (async, rst_n=0):
  - all registered outputs 0; state IDLE; timer 0; capture buffer 0.
  - reset mid-wait abandons the outstanding load; no drain.
- FSM states: IDLE, WAIT, HOLD, DRAIN.
  - IDLE, load present, rvalid=1: data used this cycle. If mem_stall_i=1, capture data and go HOLD; otherwise remain IDLE.
  - IDLE, load present, rvalid=0: go WAIT; timer clears.
  - WAIT, rvalid=1: capture data; go HOLD if mem_stall_i=1, otherwise IDLE with the result registered this cycle.
  - WAIT, rvalid=0: timer increments.
  - HOLD, mem_stall_i=0: result registered from the buffer; go IDLE.
  - DRAIN, rvalid=1: discard data; go IDLE.
- Flush:
  - mem_flush_i=1 in IDLE (load, no rvalid) or in WAIT: go DRAIN.
  - In HOLD, or in IDLE with rvalid=1: go IDLE; data discarded.
  - Flush has priority over everything.
- mem_stall_o = (load present & no data available this cycle) | state==DRAIN.
  - "data available" means rvalid this cycle, or state==HOLD.
- Load result selection, from data d = (HOLD ? buffer : dmem_rdata_i), offset a:
  - lb/lbu: byte a, sign- or zero-extended.
  - lh/lhu: a[1] selects upper/lower half; a[0] is ignored.
  - lw: d.
  - lwl (little endian):
    - a=0: {d[7:0], rt[23:0]}
    - a=1: {d[15:0], rt[15:0]}
    - a=2: {d[23:0], rt[7:0]}
    - a=3: d
  - lwr (little endian):
    - a=0: d
    - a=1: {rt[31:24], d[31:8]}
    - a=2: {rt[31:16], d[31:16]}
    - a=3: {rt[31:8], d[31:24]}
  - memop all-zero with load=1 gives result 0.
- Output register update, evaluated in priority order:
  1. mem_flush_i: load all zeros.
  2. mem_stall_i: hold.
  3. mem_stall_o: load a bubble (all zeros, wren=0).
  4. Otherwise: load {inst, pc, inslot, waddr, wren, wdata}, where wdata = load ? result : mem_wdata_i.
- Bypass outputs:
  - mem_wdata_bp = load ? result : mem_wdata_i.
  - mem_nofwd_bp = mem_nofwd_i | mem_stall_o.
- Timeout (TIMEOUT≠0):
  - In WAIT, timer==TIMEOUT-1 with rvalid=0: pulse mem_buserr_o next cycle.
  - The load then completes as a bubble with wren=0; state goes DRAIN.
  - A late rvalid is discarded in DRAIN.
- Simultaneous rvalid & timeout expiry: rvalid wins; no error.

Test Plan:
- lw, rvalid on the same cycle, rdata=0x8899AABB, no stall → mem_wdata_o=0x8899AABB the next cycle; mem_stall_o stays 0.
- lb, a=3, rvalid 3 cycles late, rdata=0x80112233 → mem_stall_o=1 for 3 cycles with bubbles out; then mem_wdata_o=0xFFFFFF80, wren=1.
- lwl and lwr, a=1, rt=0x11223344, rdata=0xAABBCCDD → lwl gives 0xCCDD3344; lwr gives 0x11AABBCC.
- rvalid arrives while mem_stall_i=1 for 2 cycles, lhu a=2, rdata=0xBEEF0000 → HOLD; outputs frozen; after release, wdata=0x0000BEEF.
- Flush during WAIT, then the old rvalid arrives with 0xDEADBEEF → no write; mem_stall_o=1 until that rvalid; a following lw then returns its own data.
- TIMEOUT=4, load with no rvalid → mem_buserr_o pulses once after 4 wait cycles; wren_o=0; a late rvalid is ignored; reset asserted mid-WAIT clears all outputs immediately.
